instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Instruction fetch stage of the SingleCycleComputer: owns the program counter, drives the instruction-memory read port (`i_mem_a`, `i_mem_en`, `i_mem_v`) of the memory module, and delivers fetched {pc, instruction} pairs to the decoder over a valid/ready handshake. It sits directly upstream of the instruction-memory port. It also accepts branch/jump redirects from execute, flushing stale fetches.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `ADDR_W`, 32, address width (fixed by ISA)
- `INSTR_W`, 32, instruction width (fixed by ISA)
- `clk` in 1, single clock, rising edge
- `rst` in 1, asynchronous, active-high reset
- `i_mem_a` out ADDR_W, instruction memory byte address
- `i_mem_en` out 1, instruction memory read enable
- `i_mem_v` in INSTR_W, instruction memory read data, valid the cycle after `i_mem_en`
- `redirect_valid` in 1, redirect request from execute
- `redirect_pc` in ADDR_W, redirect target
- `f_valid` out 1, fetched entry available
- `f_ready` in 1, decoder accepts entry
- `f_pc` out ADDR_W, address of the presented instruction
- `f_instr` out INSTR_W, presented instruction
- `fault` out 1, sticky misaligned-redirect fault

## Operation
- Byte-addressed; PC advances by 4 per issued request; 32'hFFFF_FFFC + 4 wraps to 0, no fault.
- Request issued in a cycle when `i_mem_en`=1: `i_mem_a`=PC, PC<=PC+4 at the edge.
- Issue condition: not halted, no `redirect_valid` this cycle, and (FIFO occupancy + in-flight − pop this cycle) < 2. At most one request in flight.
- Response (`i_mem_v`) paired with its issuing PC and written into a 2-entry FIFO at the end of the response cycle, unless killed.
- Pop when `f_valid && f_ready`; `f_pc`/`f_instr` are the FIFO head.
- Redirect (highest priority): PC<=`redirect_pc`, FIFO flushed, in-flight response marked killed and discarded; no request issued in the redirect cycle. Simultaneous pop in that cycle is ignored (entry flushed anyway).
- Redirect while a killed response is pending: second redirect wins; the pending response is still discarded.

## Timing
- Reset values: PC=`RESET_PC`, `i_mem_a`=`RESET_PC`, `i_mem_en`=0 while `rst` high, `f_valid`=0, `f_pc`=0, `f_instr`=0, `fault`=0, FIFO empty, nothing in flight.
- First request in the first cycle after `rst` deasserts.
- Latency: issue cycle T, `i_mem_v` sampled in T+1, `f_valid` in T+2.
- Redirect in cycle N: request for target in N+1, `f_valid` for target in N+3.
- Throughput: 1 instruction/cycle sustained with `f_ready` held high.
- `f_valid` holds and `f_pc`/`f_instr` stay stable until popped or flushed.
- Reset mid-operation: all state returns to reset values immediately (asynchronous); in-flight response after reset is ignored.

## Configuration
- `FETCH_MISALIGN_TRAP_EN` defined: redirect with `redirect_pc[1:0]`≠0 sets `fault`=1 (sticky until reset), flushes FIFO, kills in-flight, halts issue (`i_mem_en`=0, `f_valid`=0 thereafter).
- Not defined: `redirect_pc[1:0]` forced to 0, `fault` tied 0.

## Structure
- Package `fetch_pkg`: `ADDR_W`, `INSTR_W`, `PC_STEP`=4, typedef `fetch_entry_t` {pc, instr}.
- Sub-module `fetch_fifo2`: 2-entry FIFO of `fetch_entry_t` with synchronous flush, occupancy output; top holds PC, in-flight/kill flags, fault.

## Test plan
- Reset release, `f_ready`=1 → `i_mem_a` 0,4,8,… one per cycle; `f_pc`=0 with `f_valid` two cycles after first request, then 4,8 back-to-back.
- `f_ready`=0 for 5 cycles → exactly 2 entries buffered (pc 0,4), `i_mem_en` low, `f_pc` stable at 0; release → 0,4,8 delivered in order, none lost or duplicated.
- Redirect to 32'h100 while entry pending and one in flight → stale entries dropped, next delivered `f_pc`=32'h100 exactly 3 cycles after redirect.
- Redirect to 32'hFFFF_FFFC → delivered pcs FFFF_FFFC then 0, `fault`=0.
- Redirect to 32'h102: with macro → `fault`=1, `f_valid`=0, `i_mem_en`=0 until `rst`; without macro → next `f_pc`=32'h100.
- Assert `rst` mid-stream for one cycle → outputs at reset values immediately; fetch resumes at `RESET_PC`.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared widths and entry type for the instruction fetch slice.
package fetch_pkg;

  localparam int ADDR_W  = 32;
  localparam int INSTR_W = 32;

  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch unit bus: instruction-memory read port, execute redirect and decode handshake.
interface instr_fetch_unit_if;
  import fetch_pkg::*;

  logic [ADDR_W-1:0]  i_mem_a;
  logic               i_mem_en;
  logic [INSTR_W-1:0] i_mem_v;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               f_valid;
  logic               f_ready;
  logic [ADDR_W-1:0]  f_pc;
  logic [INSTR_W-1:0] f_instr;
  logic               fault;

  modport master (
    output i_mem_a, i_mem_en, f_valid, f_pc, f_instr, fault,
    input  i_mem_v, redirect_valid, redirect_pc, f_ready
  );

  modport slave (
    input  i_mem_a, i_mem_en, f_valid, f_pc, f_instr, fault,
    output i_mem_v, redirect_valid, redirect_pc, f_ready
  );

endinterface

// File: rtl/fetch_fifo2.sv
// Two-entry queue of fetched {pc, instr} pairs; flush empties it and wins over push/pop.
module fetch_fifo2
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  output fetch_entry_t head,
  output logic         valid,
  output logic [1:0]   occ
);

  fetch_entry_t mem_q [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;
  logic         pop_ok;
  logic         push_ok;

  assign pop_ok  = pop && (count != 2'd0) && !flush;
  assign push_ok = push && ((count != 2'd2) || pop_ok) && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push_ok) wr_ptr <= ~wr_ptr;
      if (pop_ok)  rd_ptr <= ~rd_ptr;
      count <= count + 2'(push_ok) - 2'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr] <= push_entry;
  end

  assign head  = mem_q[rd_ptr];
  assign valid = (count != 2'd0);
  assign occ   = count;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC, memory read request, 2-deep queue toward decode.
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_TRAP_EN.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic                clk,
  input logic                rst,
  instr_fetch_unit_if.master bus
);

  logic [ADDR_W-1:0] pc_p0;
  logic [ADDR_W-1:0] req_pc_p1;
  logic              inflight_p1;
  logic              fault_q;
  logic              halted;
  logic [ADDR_W-1:0] redirect_target;
  logic              issue;
  logic              push;
  logic              pop;
  logic              fifo_valid;
  logic [1:0]        occ;
  logic [2:0]        pending;
  fetch_entry_t      push_entry;
  fetch_entry_t      head;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misalign;

  assign misalign        = bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
  assign redirect_target = bus.redirect_pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           fault_q <= 1'b0;
    else if (misalign) fault_q <= 1'b1;
  end
`else
  assign redirect_target = bus.redirect_pc & ~ADDR_W'(3);
  assign fault_q         = 1'b0;
`endif

  assign halted = fault_q;
  assign pop    = fifo_valid && bus.f_ready;

  // Slots already claimed once this cycle's pop leaves; never below zero since pop implies occ>0.
  assign pending = {1'b0, occ} + {2'b0, inflight_p1} - {2'b0, pop};
  assign issue   = !rst && !halted && !bus.redirect_valid && (pending < 3'd2);

  // Stage p0: program counter and request issue
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_p0       <= RESET_PC;
      inflight_p1 <= 1'b0;
    end else begin
      inflight_p1 <= issue;
      if (bus.redirect_valid) pc_p0 <= redirect_target;
      else if (issue)         pc_p0 <= pc_p0 + PC_STEP;
    end
  end

  always_ff @(posedge clk) begin
    if (issue) req_pc_p1 <= pc_p0;
  end

  // Stage p1: response capture; a response landing in a redirect cycle is stale
  assign push       = inflight_p1 && !bus.redirect_valid;
  assign push_entry = '{pc: req_pc_p1, instr: bus.i_mem_v};

  fetch_fifo2 u_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (bus.redirect_valid),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .valid      (fifo_valid),
    .occ        (occ)
  );

  assign bus.i_mem_a  = pc_p0;
  assign bus.i_mem_en = issue;
  assign bus.f_valid  = fifo_valid;
  assign bus.f_pc     = fifo_valid ? head.pc : '0;
  assign bus.f_instr  = fifo_valid ? head.instr : '0;
  assign bus.fault    = fault_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus random ready/redirect traffic
// scored against an in-order expected-PC stream and a synthetic instruction memory.
module tb_instr_fetch_unit;
  import fetch_pkg::*;

  logic clk = 1'b0;
  logic rst;

  instr_fetch_unit_if bus();

  instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int pops   = 0;

  logic        o_en, o_fv, o_fault;
  logic [31:0] o_a, o_pc, o_instr;

  logic [31:0] m_pc;
  logic        m_halt;
  logic        hold_prev;
  logic [31:0] hold_pc, hold_instr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: apply inputs, observe, score, clock, answer the memory read.
  task automatic cyc(input logic rdy, input logic rv, input logic [31:0] rpc);
    logic        en_s;
    logic [31:0] a_s;
    bus.f_ready        = rdy;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    #1;
    o_en    = bus.i_mem_en;
    o_a     = bus.i_mem_a;
    o_fv    = bus.f_valid;
    o_pc    = bus.f_pc;
    o_instr = bus.f_instr;
    o_fault = bus.fault;
    if (hold_prev) begin
      chk("hold_valid", 32'(o_fv), 32'd1);
      chk("hold_pc", o_pc, hold_pc);
      chk("hold_instr", o_instr, hold_instr);
    end
    if (m_halt) begin
      chk("halt_en", 32'(o_en), 32'd0);
      chk("halt_valid", 32'(o_fv), 32'd0);
      chk("halt_fault", 32'(o_fault), 32'd1);
    end
    if (rv) begin
`ifdef FETCH_MISALIGN_TRAP_EN
      if (rpc[1:0] != 2'b00) m_halt = 1'b1;
`endif
      m_pc = rpc & ~32'd3;
    end else if (o_fv && rdy) begin
      chk("pop_pc", o_pc, m_pc);
      chk("pop_instr", o_instr, mem_word(m_pc));
      m_pc = m_pc + 32'd4;
      pops++;
    end
    hold_prev  = o_fv && !rdy && !rv;
    hold_pc    = o_pc;
    hold_instr = o_instr;
    en_s = o_en;
    a_s  = o_a;
    @(posedge clk);
    #1;
    bus.i_mem_v = en_s ? mem_word(a_s) : $urandom();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.f_ready        = 1'b0;
    bus.redirect_valid = 1'b0;
    #1;
    chk("rst_en", 32'(bus.i_mem_en), 32'd0);
    chk("rst_a", bus.i_mem_a, 32'h0);
    chk("rst_valid", 32'(bus.f_valid), 32'd0);
    chk("rst_pc", bus.f_pc, 32'h0);
    chk("rst_instr", bus.f_instr, 32'h0);
    chk("rst_fault", 32'(bus.fault), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    rst       = 1'b0;
    m_pc      = 32'h0;
    m_halt    = 1'b0;
    hold_prev = 1'b0;
  endtask

  initial begin
    int ens;
    logic        rdy, rv;
    logic [31:0] tgt;

    rst                = 1'b1;
    bus.i_mem_v        = '0;
    bus.f_ready        = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    m_pc = 0; m_halt = 0; hold_prev = 0; hold_pc = 0; hold_instr = 0;
    @(negedge clk);

    // Streaming from reset with decode always ready
    do_reset();
    for (int k = 0; k < 7; k++) begin
      cyc(1'b1, 1'b0, 32'h0);
      chk("t1_en", 32'(o_en), 32'd1);
      chk("t1_a", o_a, 32'(4 * k));
      if (k < 2) chk("t1_valid", 32'(o_fv), 32'd0);
      else begin
        chk("t1_valid", 32'(o_fv), 32'd1);
        chk("t1_pc", o_pc, 32'(4 * (k - 2)));
      end
    end

    // Decode stalled: exactly two requests issued, head held at pc 0
    do_reset();
    ens = 0;
    for (int k = 0; k < 5; k++) begin
      cyc(1'b0, 1'b0, 32'h0);
      ens += int'(o_en);
      if (k >= 2) begin
        chk("t2_en", 32'(o_en), 32'd0);
        chk("t2_valid", 32'(o_fv), 32'd1);
        chk("t2_pc", o_pc, 32'h0);
      end
    end
    chk("t2_issued", 32'(ens), 32'd2);
    for (int k = 0; k < 6; k++) begin
      cyc(1'b1, 1'b0, 32'h0);
      chk("t2_drain_pc", o_pc, 32'(4 * k));
    end

    // Redirect with an entry queued and one in flight
    cyc(1'b1, 1'b1, 32'h100);
    chk("t3_redir_en", 32'(o_en), 32'd0);
    cyc(1'b1, 1'b0, 32'h0);
    chk("t3_req_a", o_a, 32'h100);
    chk("t3_req_en", 32'(o_en), 32'd1);
    chk("t3_n1_valid", 32'(o_fv), 32'd0);
    cyc(1'b1, 1'b0, 32'h0);
    chk("t3_n2_valid", 32'(o_fv), 32'd0);
    cyc(1'b1, 1'b0, 32'h0);
    chk("t3_n3_valid", 32'(o_fv), 32'd1);
    chk("t3_n3_pc", o_pc, 32'h100);

    // Wrap at top of address space
    cyc(1'b1, 1'b1, 32'hFFFF_FFFC);
    cyc(1'b1, 1'b0, 32'h0);
    chk("t4_a0", o_a, 32'hFFFF_FFFC);
    cyc(1'b1, 1'b0, 32'h0);
    chk("t4_a1", o_a, 32'h0);
    cyc(1'b1, 1'b0, 32'h0);
    chk("t4_pc0", o_pc, 32'hFFFF_FFFC);
    cyc(1'b1, 1'b0, 32'h0);
    chk("t4_pc1", o_pc, 32'h0);
    chk("t4_fault", 32'(o_fault), 32'd0);

    // Misaligned redirect
    cyc(1'b1, 1'b1, 32'h102);
`ifdef FETCH_MISALIGN_TRAP_EN
    for (int k = 0; k < 5; k++) cyc(1'b1, 1'b0, 32'h0);
    chk("t5_fault", 32'(o_fault), 32'd1);
`else
    cyc(1'b1, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 32'h0);
    chk("t5_pc", o_pc, 32'h100);
    chk("t5_fault", 32'(o_fault), 32'd0);
`endif

    // Reset pulse mid-stream, then fetch resumes at the reset PC
    do_reset();
    for (int k = 0; k < 4; k++) cyc(1'b1, 1'b0, 32'h0);
    do_reset();
    cyc(1'b1, 1'b0, 32'h0);
    chk("t6_a", o_a, 32'h0);
    chk("t6_en", 32'(o_en), 32'd1);
    cyc(1'b1, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 32'h0);
    chk("t6_valid", 32'(o_fv), 32'd1);
    chk("t6_pc", o_pc, 32'h0);

    // Random decode back-pressure and redirects
    for (int i = 0; i < 400; i++) begin
      rdy = ($urandom_range(0, 3) != 0);
      rv  = ($urandom_range(0, 15) == 0);
      tgt = $urandom();
`ifdef FETCH_MISALIGN_TRAP_EN
      tgt = tgt & ~32'd3;
`endif
      cyc(rdy, rv, tgt);
    end
    for (int k = 0; k < 4; k++) cyc(1'b1, 1'b0, 32'h0);
    chk("rand_drain_valid", 32'(o_fv), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
